// File: rtl/stack_unit.sv
// stack_unit: parametrised downward-growing stack with a registered top
// entry, full/empty status, sticky overflow/underflow flags and a
// tri-state view of the top entry for the shared data bus.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             oe,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      sp,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  // Entries below the top; mem[i] is the entry whose index is i once it
  // has been pushed down under a newer top.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] top_q;
  logic             ovf_q, unf_q;

  op_e              op;
  logic             do_push;   // a new entry goes on (plain push or push+pop on empty)
  logic             do_pop;
  logic             do_repl;
  logic             ovf_evt, unf_evt;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign count = count_q;
  assign sp    = DEPTH_C - count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign top   = top_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign bus_out = oe ? top_q : {WIDTH{1'bz}};

  // Old top lands at the current sp; after a pop the new top is one above it.
  assign wr_idx = sp[AW-1:0];
  assign rd_idx = sp[AW-1:0] + AW'(1);

  // Decode the requested operation against the current occupancy.
  always_comb begin
    op      = op_e'({push, pop});
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      OP_PUSH: if (full) ovf_evt = 1'b1; else do_push = 1'b1;
      OP_POP:  if (empty) unf_evt = 1'b1; else do_pop = 1'b1;
      OP_REPL: if (empty) do_push = 1'b1; else do_repl = 1'b1;
      default: ;
    endcase
  end

  // Pointer, top register and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // A new event in the same cycle as clear_err keeps the flag set.
      ovf_q <= ovf_evt | (ovf_q & ~clear_err);
      unf_q <= unf_evt | (unf_q & ~clear_err);
      if (do_push) begin
        top_q   <= din;
        count_q <= count_q + (AW+1)'(1);
      end else if (do_repl) begin
        top_q   <= din;
      end else if (do_pop) begin
        top_q   <= (count_q > (AW+1)'(1)) ? mem[rd_idx] : '0;
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // Push the previous top down into storage; an empty stack has none.
  always_ff @(posedge clk) begin
    if (!reset && do_push && !empty)
      mem[wr_idx] <= top_q;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised hardware stack: stack pointer and stack storage in one block, replacing the fixed 8-bit down-counter and RAM-backed stack of the CoCC computer.
- Configurable data width and depth.
- Push, pop and replace-top operations.
- Full/empty status, sticky overflow/underflow error flags, and a tri-state bus driver for the shared data bus.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; power of two, >= 2.
- AW, $clog2(DEPTH), derived address width; do not override.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  push din onto the stack this cycle.
- pop  input  1  remove top entry this cycle.
- din  input  WIDTH  data to push.
- oe  input  1  bus output enable.
- bus_out  output  WIDTH  top of stack when oe=1, high-Z otherwise.
- top  output  WIDTH  top of stack, always driven.
- sp  output  AW+1  stack pointer: index of the current top entry; equals DEPTH when empty; decrements on push (downward growth).
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.
- clear_err  input  1  clears overflow and underflow.

Behaviour:
- Reset is synchronous and active-high. When reset=1 at an edge:
  - count=0, sp=DEPTH, top=0, overflow=0, underflow=0.
  - Storage contents are don't-care.
  - reset overrides all other inputs in that cycle, including reset mid-operation.
- Storage:
  - The top entry is held in a dedicated register `top`.
  - Entries below it sit in an internal array indexed by sp.
  - top and all flags are registered. New values are visible the cycle after the edge that performs the operation.
- Operations are decoded each edge from {push,pop}:
  - 00: hold.
  - 10, not full: the previous top is written into the array (only if count>0), top<=din, count+1, sp-1.
  - 10, full: no state change except overflow<=1.
  - 01, not empty: top<=array entry directly below the old top (0 if count becomes 0), count-1, sp+1.
  - 01, empty: no state change except underflow<=1; top stays 0.
  - 11, not empty: replace top, top<=din; count and sp unchanged; no error even when full.
  - 11, empty: behaves as a plain push; no underflow.
- Invariant: sp == DEPTH - count at all times. No wrap-around: count never exceeds DEPTH or drops below 0.
- Error flags:
  - clear_err=1 clears both flags at the edge.
  - If a new overflow/underflow event occurs in the same cycle as clear_err, the flag is set (event wins).
- bus_out is combinational from oe and top: WIDTH'bz when oe=0. It does not affect internal state.
- Combinational status: empty and full are decoded from the registered count, with no extra latency.

Test Plan:
- Reset, DEPTH=4, WIDTH=8 -> count=0, sp=4, empty=1, full=0, top=0x00, overflow=0, underflow=0; with oe=0, bus_out=8'hzz.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> after the 4th edge: count=4, sp=0, full=1, top=0x44; one more push of 0x55 -> state unchanged, overflow=1.
- From full, pop four times -> top shows 0x33, 0x22, 0x11, 0x00 after successive edges, empty=1, sp=4; a fifth pop -> underflow=1, count stays 0.
- Push 0xA0 then push+pop with din=0xB0 -> top=0xB0, count=1; on a full stack push+pop with 0xCC -> top=0xCC, count=4, overflow stays 0.
- Set overflow, then clear_err alone -> overflow=0; with full stack, clear_err and push in the same cycle -> overflow=1.
- Push 0x11, 0x22, then reset asserted together with push of 0x99 -> count=0, sp=4, top=0x00; oe=1 -> bus_out=0x00.
